// File: rtl/bidir_bus_port.sv
// ----------------------------------------------------------------------------
// bidir_bus_port
//
// Half-duplex controller for a WIDTH-bit bank of tri-state pad buffers.
// Turns single-cycle write/read requests from a PicoBlaze port decoder into
// sequenced pad enables: a write drives the pads for DRIVE_CYCLES, then holds
// them released for TURN_CYCLES of dead time; a read samples the pads through
// a SYNC_STAGES-deep synchroniser. Requests are only taken while idle.
//
// Ports
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   wr_req    in   write request pulse (sampled only when idle)
//   wr_data   in   write value, captured with wr_req
//   wr_ack    out  one-cycle pulse in the first released cycle after a write
//   rd_req    in   read request pulse (sampled only when idle)
//   rd_data   out  last captured read value, held until the next read
//   rd_valid  out  one-cycle pulse when rd_data updates
//   busy      out  high whenever a transfer is in progress
//   wr_err    out  sticky loopback mismatch flag (0 unless feature enabled)
//   pad_i     out  to pad buffer I inputs
//   pad_t     out  to pad buffer T inputs, 1 = hi-Z, all bits identical
//   pad_o     in   from pad buffer O outputs, asynchronous to clk
//
// Optional feature
//   BIDIR_BUS_LOOPBACK_CHECK_EN : when defined, the synchronised pad value is
//   compared against the driven value on the last drive cycle; a mismatch sets
//   wr_err together with wr_ack. Only active when DRIVE_CYCLES > SYNC_STAGES.
// ----------------------------------------------------------------------------
module bidir_bus_port #(
    parameter int WIDTH        = 8,
    parameter int DRIVE_CYCLES = 2,
    parameter int TURN_CYCLES  = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             wr_err,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_o
);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

    // One shared down-counter, sized for the longest phase.
    localparam int MAX_DS  = (DRIVE_CYCLES > SYNC_STAGES) ? DRIVE_CYCLES : SYNC_STAGES;
    localparam int CNT_MAX = ((MAX_DS > TURN_CYCLES) ? MAX_DS : TURN_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_STAGES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // Registered outputs; pad_t is derived from a single drive flag so every
    // bit of the enable bus switches together.
    logic             drive_q, drive_next;
    logic [WIDTH-1:0] pad_i_q, pad_i_next;
    logic             wr_ack_q, wr_ack_next;
    logic             rd_valid_q, rd_valid_next;
    logic [WIDTH-1:0] rd_data_q, rd_data_next;

    // ------------------------------------------------------------------
    // Input synchroniser on the asynchronous pad readback
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_o;

    // NOTE: the synchroniser chain is reset like any other state so a read
    // straight after reset cannot return stale pre-reset pad data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad_o;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State register (FSM state, counter and registered outputs)
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            drive_q    <= 1'b0;
            pad_i_q    <= '0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            drive_q    <= drive_next;
            pad_i_q    <= pad_i_next;
            wr_ack_q   <= wr_ack_next;
            rd_valid_q <= rd_valid_next;
            rd_data_q  <= rd_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                // A simultaneous read is dropped: the write wins.
                if (wr_req) begin
                    state_next = DRIVE;
                    cnt_next   = DRIVE_LOAD;
                end else if (rd_req) begin
                    state_next = SAMPLE;
                    cnt_next   = SYNC_LOAD;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    if (TURN_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = TURN;
                        cnt_next   = TURN_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            TURN, SAMPLE: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        drive_next    = drive_q;
        pad_i_next    = pad_i_q;
        wr_ack_next   = 1'b0;
        rd_valid_next = 1'b0;
        rd_data_next  = rd_data_q;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    pad_i_next = wr_data;
                    drive_next = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    drive_next  = 1'b0;
                    wr_ack_next = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    rd_data_next  = sync_o;
                    rd_valid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
    // The readback only reflects the driven value once the synchroniser has
    // filled with post-drive samples, so shorter drives skip the compare.
    localparam bit LOOPBACK_OK = (DRIVE_CYCLES > SYNC_STAGES);

    logic wr_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_q <= 1'b0;
        end else if (state == IDLE && wr_req) begin
            wr_err_q <= 1'b0;
        end else if (LOOPBACK_OK && state == DRIVE && cnt == '0 && sync_o != pad_i_q) begin
            wr_err_q <= 1'b1;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign pad_t    = {WIDTH{~drive_q}};
    assign pad_i    = pad_i_q;
    assign wr_ack   = wr_ack_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state != IDLE);

endmodule
